// File: rtl/rr_analyzer_pkg.sv
// rtl/rr_analyzer_pkg.sv - shared constants, FSM states and divider step for rr_analyzer
package rr_analyzer_pkg;

  localparam int FS_HZ = 360;
  localparam int RR_W  = 16;
  localparam int NUM_W = 24;
  localparam int SUM_W = RR_W + 3;

  localparam logic [RR_W-1:0]  RR_MIN    = RR_W'(72);
  localparam logic [RR_W-1:0]  RR_MAX    = RR_W'(1080);
  localparam logic [RR_W-1:0]  QRS_WIDE  = RR_W'(43);
  localparam logic [7:0]       BRADY_BPM = 8'd60;
  localparam logic [7:0]       TACHY_BPM = 8'd100;
  localparam logic [NUM_W-1:0] BPM_NUM   = NUM_W'(60 * FS_HZ);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    UPDATE,
    DIVIDE,
    DONE
  } state_t;

  // One restoring-division step: returns {remainder, dividend/quotient shift register}.
  function automatic logic [RR_W+NUM_W-1:0] div_step(input logic [RR_W-1:0]  rem,
                                                     input logic [NUM_W-1:0] dq,
                                                     input logic [RR_W-1:0]  den);
    logic [RR_W:0] shifted;
    shifted = {rem, dq[NUM_W-1]};
    if (shifted >= {1'b0, den})
      div_step = {RR_W'(shifted - {1'b0, den}), dq[NUM_W-2:0], 1'b1};
    else
      div_step = {shifted[RR_W-1:0], dq[NUM_W-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/rr_div.sv
// rtl/rr_div.sv - start/done restoring divider, one quotient bit per clock
module rr_div
  import rr_analyzer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [RR_W-1:0]  den,
  output logic             done,
  output logic [NUM_W-1:0] quot
);

  logic [RR_W-1:0]         rem;
  logic [RR_W-1:0]         den_q;
  logic [4:0]              cnt;
  logic [RR_W+NUM_W-1:0]   step_first;
  logic [RR_W+NUM_W-1:0]   step_next;

  // The first step runs on the start edge, so 24 steps end one edge earlier.
  assign step_first = div_step('0, num, den);
  assign step_next  = div_step(rem, quot, den_q);

  // Iterate until the step counter drains; done pulses once the last bit lands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem   <= '0;
      quot  <= '0;
      den_q <= '0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        {rem, quot} <= step_first;
        den_q       <= den;
        cnt         <= 5'd23;
      end else if (cnt != 5'd0) begin
        {rem, quot} <= step_next;
        cnt         <= cnt - 5'd1;
        if (cnt == 5'd1)
          done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_analyzer.sv
// rtl/rr_analyzer.sv - R-R interval validation, 8-beat average, BPM and rhythm flags
module rr_analyzer
  import rr_analyzer_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            rr_valid,
  input  logic [RR_W-1:0] rr_int,
  input  logic [RR_W-1:0] qrs_w,
  output logic            busy,
  output logic            hr_valid,
  output logic [7:0]      bpm,
  output logic [RR_W-1:0] rr_avg,
  output logic            brady,
  output logic            tachy,
  output logic            irregular,
  output logic            wide_qrs,
  output logic            artifact,
  output logic            overrun
);

  state_t           state;
  logic             first_seen;
  logic [RR_W-1:0]  rr_q;
  logic [RR_W-1:0]  qrs_q;
  logic [RR_W-1:0]  rr_buf [8];
  logic [2:0]       wp;
  logic [3:0]       fill;
  logic [SUM_W-1:0] sum;
  logic             irr_next;

  logic             warm;
  logic [RR_W-1:0]  diff;
  logic [SUM_W-1:0] sum_next;
  logic             div_start;
  logic [RR_W-1:0]  div_den;
  logic             div_done;
  logic [NUM_W-1:0] quot;
  logic [7:0]       bpm_sat;

  assign busy      = (state != IDLE);
  assign warm      = (fill == 4'd8);
  assign diff      = (rr_q >= rr_avg) ? (rr_q - rr_avg) : (rr_avg - rr_q);
  assign sum_next  = sum - {3'b000, rr_buf[wp]} + {3'b000, rr_q};
  // The divider is launched from UPDATE with the new average so it finishes as DIVIDE ends.
  assign div_start = (state == UPDATE) && (fill >= 4'd7);
  assign div_den   = RR_W'(sum_next >> 3);
  assign bpm_sat   = (|quot[NUM_W-1:8]) ? 8'hff : quot[7:0];

  rr_div u_div (
    .clk   (clk),
    .rst   (rst),
    .start (div_start),
    .num   (BPM_NUM),
    .den   (div_den),
    .done  (div_done),
    .quot  (quot)
  );

  // Beat-processing FSM with registered results and strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      first_seen <= 1'b0;
      rr_q       <= '0;
      qrs_q      <= '0;
      for (int i = 0; i < 8; i++) rr_buf[i] <= '0;
      wp         <= '0;
      fill       <= '0;
      sum        <= '0;
      irr_next   <= 1'b0;
      hr_valid   <= 1'b0;
      bpm        <= '0;
      rr_avg     <= '0;
      brady      <= 1'b0;
      tachy      <= 1'b0;
      irregular  <= 1'b0;
      wide_qrs   <= 1'b0;
      artifact   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      hr_valid <= 1'b0;
      artifact <= 1'b0;
      overrun  <= rr_valid && (state != IDLE);
      case (state)
        IDLE: begin
          if (rr_valid) begin
            if (!first_seen) begin
              first_seen <= 1'b1;
            end else begin
              rr_q  <= rr_int;
              qrs_q <= qrs_w;
              state <= CHECK;
            end
          end
        end
        CHECK: begin
          if (rr_q < RR_MIN || rr_q > RR_MAX) begin
            artifact <= 1'b1;
            state    <= IDLE;
          end else begin
            irr_next <= warm && (diff > (rr_avg >> 2));
            state    <= UPDATE;
          end
        end
        UPDATE: begin
          rr_buf[wp] <= rr_q;
          sum        <= sum_next;
          wp         <= wp + 3'd1;
          if (fill != 4'd8)
            fill <= fill + 4'd1;
          state <= (fill >= 4'd7) ? DIVIDE : IDLE;
        end
        DIVIDE: begin
          if (div_done) begin
            bpm       <= bpm_sat;
            rr_avg    <= RR_W'(sum >> 3);
            brady     <= (bpm_sat < BRADY_BPM);
            tachy     <= (bpm_sat > TACHY_BPM);
            irregular <= irr_next;
            wide_qrs  <= (qrs_q > QRS_WIDE);
            hr_valid  <= 1'b1;
            state     <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_analyzer.sv
// tb/tb_rr_analyzer.sv - directed self-checking bench for rr_analyzer
module tb_rr_analyzer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rr_valid = 1'b0;
  logic [15:0] rr_int = '0;
  logic [15:0] qrs_w = '0;
  logic        busy, hr_valid, brady, tachy, irregular, wide_qrs, artifact, overrun;
  logic [7:0]  bpm;
  logic [15:0] rr_avg;

  int n_chk  = 0;
  int n_pass = 0;
  int hr, art, ovr, bsy;

  always #5 clk = ~clk;

  rr_analyzer dut (
    .clk       (clk),
    .rst       (rst),
    .rr_valid  (rr_valid),
    .rr_int    (rr_int),
    .qrs_w     (qrs_w),
    .busy      (busy),
    .hr_valid  (hr_valid),
    .bpm       (bpm),
    .rr_avg    (rr_avg),
    .brady     (brady),
    .tachy     (tachy),
    .irregular (irregular),
    .wide_qrs  (wide_qrs),
    .artifact  (artifact),
    .overrun   (overrun)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Issue one beat in cycle N, then observe cycles N+1..N+35 at the falling edge.
  // Optional extra strobe at N+ovr_at and reset pulse starting at N+rst_at.
  task automatic run_beat(input int rr, input int qrs, input int ovr_at, input int rst_at,
                          output int hr_c, output int art_c, output int ovr_c, output int busy_n);
    hr_c = -1; art_c = -1; ovr_c = -1; busy_n = 0;
    @(negedge clk);
    rr_valid = 1'b1;
    rr_int   = 16'(rr);
    qrs_w    = 16'(qrs);
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      if (hr_valid && hr_c < 0)  hr_c  = k;
      if (artifact && art_c < 0) art_c = k;
      if (overrun && ovr_c < 0)  ovr_c = k;
      if (busy) busy_n++;
      if (k == 1) rr_valid = 1'b0;
      if (ovr_at != 0 && k == ovr_at) begin
        rr_valid = 1'b1;
        rr_int   = 16'd100;
      end
      if (ovr_at != 0 && k == ovr_at + 1) rr_valid = 1'b0;
      if (rst_at != 0 && k == rst_at) rst = 1'b0;
      if (rst_at != 0 && k == rst_at + 2) rst = 1'b1;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_strobes", int'({hr_valid, busy, artifact, overrun}), 0);
    chk("reset_flags", int'({brady, tachy, irregular, wide_qrs}), 0);
    chk("reset_bpm", int'(bpm), 0);
    chk("reset_rr_avg", int'(rr_avg), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // First beat after reset is discarded entirely.
    run_beat(360, 30, 0, 0, hr, art, ovr, bsy);
    chk("discard_busy", bsy, 0);
    chk("discard_hr", hr, -1);

    for (int i = 0; i < 7; i++) begin
      run_beat(360, 30, 0, 0, hr, art, ovr, bsy);
      chk($sformatf("warmup%0d_hr", i), hr, -1);
      if (i == 0) chk("warmup_busy", bsy, 2);
    end
    run_beat(360, 30, 0, 0, hr, art, ovr, bsy);
    chk("warm360_hr_cycle", hr, 27);
    chk("warm360_busy", bsy, 27);
    chk("warm360_bpm", int'(bpm), 60);
    chk("warm360_avg", int'(rr_avg), 360);
    chk("warm360_flags", int'({brady, tachy, irregular, wide_qrs}), 0);

    for (int i = 0; i < 8; i++) run_beat(300, 30, 0, 0, hr, art, ovr, bsy);
    chk("warm300_bpm", int'(bpm), 72);
    chk("warm300_avg", int'(rr_avg), 300);

    run_beat(200, 50, 0, 0, hr, art, ovr, bsy);
    chk("irr_hr_cycle", hr, 27);
    chk("irr_flag", int'(irregular), 1);
    chk("irr_avg", int'(rr_avg), 287);
    chk("irr_bpm", int'(bpm), 75);
    chk("wide_qrs50", int'(wide_qrs), 1);

    for (int i = 0; i < 8; i++) run_beat(300, 40, 0, 0, hr, art, ovr, bsy);
    chk("refill_bpm", int'(bpm), 72);
    chk("wide_qrs40", int'(wide_qrs), 0);
    chk("refill_irr", int'(irregular), 0);

    begin
      int bad [4] = '{50, 2000, 71, 1081};
      foreach (bad[i]) begin
        run_beat(bad[i], 30, 0, 0, hr, art, ovr, bsy);
        chk($sformatf("art%0d_cycle", bad[i]), art, 2);
        chk($sformatf("art%0d_hr", bad[i]), hr, -1);
        chk($sformatf("art%0d_busy", bad[i]), bsy, 1);
      end
    end
    run_beat(300, 30, 0, 0, hr, art, ovr, bsy);
    chk("post_art_hr", hr, 27);
    chk("post_art_bpm", int'(bpm), 72);
    chk("post_art_avg", int'(rr_avg), 300);
    chk("post_art_irr", int'(irregular), 0);

    for (int i = 0; i < 8; i++) run_beat(72, 30, 0, 0, hr, art, ovr, bsy);
    chk("min_rr_bpm_sat", int'(bpm), 255);
    chk("min_rr_avg", int'(rr_avg), 72);
    chk("min_rr_tachy", int'({brady, tachy}), 1);

    for (int i = 0; i < 8; i++) run_beat(600, 30, 0, 0, hr, art, ovr, bsy);
    chk("slow_bpm", int'(bpm), 36);
    chk("slow_brady", int'({brady, tachy}), 2);

    run_beat(1080, 30, 0, 0, hr, art, ovr, bsy);
    chk("max_rr_hr", hr, 27);
    chk("max_rr_avg", int'(rr_avg), 660);
    chk("max_rr_bpm", int'(bpm), 32);
    chk("max_rr_irr", int'(irregular), 1);

    // Second strobe while busy is dropped and flagged; first beat's result stands.
    run_beat(600, 30, 5, 0, hr, art, ovr, bsy);
    chk("ovr_cycle", ovr, 6);
    chk("ovr_hr_cycle", hr, 27);
    chk("ovr_avg", int'(rr_avg), 660);
    chk("ovr_bpm", int'(bpm), 32);
    chk("ovr_irr", int'(irregular), 0);

    // Reset in the middle of the divide aborts the beat.
    run_beat(600, 30, 0, 10, hr, art, ovr, bsy);
    chk("rst_mid_hr", hr, -1);
    chk("rst_mid_bpm", int'(bpm), 0);
    chk("rst_mid_avg", int'(rr_avg), 0);
    chk("rst_mid_flags", int'({brady, tachy, irregular, wide_qrs, busy}), 0);
    run_beat(600, 30, 0, 0, hr, art, ovr, bsy);
    chk("rst_discard_busy", bsy, 0);
    run_beat(600, 30, 0, 0, hr, art, ovr, bsy);
    chk("rst_cold_hr", hr, -1);
    chk("rst_cold_busy", bsy, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rr_analyzer.md
# rr_analyzer

Downstream of the QRS stage: consumes each R-R interval (in sample-clock counts) and QRS width as an R-peak is reported. Rejects physiologically impossible intervals, keeps an 8-beat running average, and converts it to beats-per-minute with a sequential divider. Raises bradycardia, tachycardia, irregular-rhythm and wide-QRS flags for the display/alarm logic.

## Interface
- FS_HZ, 360: sample rate; one clk per sample.
- RR_W, `data_output (16): width of interval and QRS-width inputs.
- RR_MIN, 72: shortest accepted interval in samples (200 ms).
- RR_MAX, 1080: longest accepted interval in samples (3 s).
- BRADY_BPM, 60 / TACHY_BPM, 100: rate thresholds.
- QRS_WIDE, 43: QRS width above which wide_qrs is set (120 ms).
- clk  in  1  sample clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- rr_valid  in  1  one-cycle strobe, high in the cycle after the R-peak register update.
- rr_int  in  RR_W  R-R interval, sampled when rr_valid=1.
- qrs_w  in  RR_W  latest QRS width, sampled when rr_valid=1.
- busy  out  1  high whenever the FSM is not in IDLE.
- hr_valid  out  1  one-cycle strobe: bpm, rr_avg and flags updated.
- bpm  out  8  heart rate, saturated at 255.
- rr_avg  out  RR_W  mean of last 8 accepted intervals.
- brady, tachy, irregular, wide_qrs  out  1 each  status flags, held between hr_valid strobes.
- artifact  out  1  one-cycle strobe: interval rejected.
- overrun  out  1  one-cycle strobe: rr_valid arrived while busy.

## Operation
- FSM: IDLE, CHECK, UPDATE, DIVIDE, DONE.
- IDLE: on rr_valid capture rr_int and qrs_w, go CHECK. rr_valid in any other state is dropped and pulses overrun.
- First rr_valid after reset is always discarded (interval spans reset, not two beats); IDLE stays IDLE, no other output.
- CHECK: if rr < RR_MIN or rr > RR_MAX, pulse artifact, return IDLE; buffer untouched. Else compute irregular_next = warm && |rr - rr_avg| > (rr_avg >> 2), go UPDATE.
- UPDATE: 8-entry circular buffer, 3-bit write pointer wraps 7->0. sum <= sum - buf[wp] + rr (sum width RR_W+3, unsigned, never overflows). buf[wp] <= rr; wp++; fill count saturates at 8. If count now 8 (warm), go DIVIDE, else IDLE.
- DIVIDE: rr_avg = sum >> 3 (floor). Restoring divider, 24 iterations, 1 quotient bit per clk: quotient = floor(60*FS_HZ / rr_avg), 24-bit numerator.
- DONE: bpm = min(quotient, 255); brady = bpm < BRADY_BPM; tachy = bpm > TACHY_BPM; irregular = irregular_next; wide_qrs = qrs_w > QRS_WIDE; hr_valid=1; go IDLE.
- Reset (any state, incl. mid-divide): FSM IDLE, buffer/sum/count/pointer cleared, first-beat flag cleared, all outputs 0; no hr_valid for the aborted beat.

## Timing
- rr_valid high in cycle N (FSM IDLE): CHECK N+1, UPDATE N+2, DIVIDE N+3..N+26, DONE N+27.
- hr_valid high exactly in cycle N+27; bpm/rr_avg/flags change in that cycle and hold.
- artifact high in cycle N+2 (registered from CHECK); FSM IDLE from N+2.
- busy high N+1..N+27 (N+1 only for rejected; N+1..N+2 during warm-up).
- Accepted-beat latency 27 < RR_MIN, so overrun never occurs for legal streams.
- overrun high the cycle after the dropped rr_valid.

## Structure
- Shared include `parameters.v`: add `rr_min, `rr_max, `brady_bpm, `tachy_bpm, `qrs_wide, `fs_hz alongside existing `data_output/`qrs_limit.
- Sub-module rr_div: start/done restoring divider, 24-bit numerator, RR_W denominator, 24-bit quotient, same clk/rst.

## Test plan
- After reset, discard beat then 8 × rr_int=360 (FS 360) -> no hr_valid for first 7 accepted; 8th gives hr_valid at N+27, bpm=60, rr_avg=360, brady=0, tachy=0.
- Warm at 300 -> bpm=72; then rr_int=200 -> irregular=1, rr_avg=287, bpm=75.
- rr_int=50 and rr_int=2000 when warm -> artifact at N+2, no hr_valid, next 300 beat yields unchanged-history result.
- 8 × rr_int=72 -> quotient 300, bpm=255 (saturated), tachy=1; 8 × 600 -> bpm=36, brady=1.
- qrs_w=50 with accepted beat -> wide_qrs=1; qrs_w=40 -> 0.
- rst low at N+10 mid-divide -> no hr_valid, outputs 0; rr_valid while busy -> overrun pulse, result of first beat unaffected.
